// File: rtl/lif_pkg.sv
// Shared types, default constants and the saturating adder for the LIF scheduler.
package lif_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } lif_fsm_e;

  localparam int DEF_THRESHOLD  = 200;
  localparam int DEF_LEAK_SHIFT = 1;
  localparam int DEF_REFRACT    = 2;

  // Unsigned add of two w-bit values, clamped to 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] s;
    logic [31:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (s > {1'b0, m}) ? m : s[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Combinational single-neuron LIF update: leak, integrate, saturate, refractory, fire.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRACT    = DEF_REFRACT,
  parameter int RW         = 2
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [RW-1:0]    refr_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic [WIDTH-1:0] next_state_o,
  output logic [RW-1:0]    next_refr_o,
  output logic             fire_o
);

  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] sum_w;

  // Refractory neurons are held at zero; otherwise integrate and compare.
  always_comb begin
    leaked       = state_i >> LEAK_SHIFT;
    sum_w        = WIDTH'(sat_add(32'(cur_i), 32'(leaked), WIDTH));
    next_state_o = state_i;
    next_refr_o  = refr_i;
    fire_o       = 1'b0;
    if (refr_i != '0) begin
      next_state_o = '0;
      next_refr_o  = refr_i - RW'(1);
    end else if (sum_w >= threshold_i) begin
      next_state_o = '0;
      next_refr_o  = RW'(REFRACT);
      fire_o       = 1'b1;
    end else begin
      next_state_o = sum_w;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF population controller: one neuron per cycle per time step,
// spikes leave through a single-entry valid/ready register.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and a raised spike_valid holds spike_idx
// stable until accepted.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int WIDTH       = 8,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int REFRACT     = DEF_REFRACT,
  localparam int IW         = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_valid,
  output logic             step_ready,
  output logic             step_done,
  output logic [IW-1:0]    cur_idx,
  input  logic [WIDTH-1:0] cur_data,
  output logic             spike_valid,
  output logic [IW-1:0]    spike_idx,
  input  logic             spike_ready,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_threshold,
  input  logic [IW-1:0]    dbg_idx,
  output logic [WIDTH-1:0] dbg_state
);

  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

  lif_fsm_e         fsm_q, fsm_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q;
  logic             spk_valid_q;
  logic [IW-1:0]    spk_idx_q;
  logic [WIDTH-1:0] thr_q;
  logic [WIDTH-1:0] state_q [NUM_NEURONS];
  logic [RW-1:0]    refr_q  [NUM_NEURONS];

  logic [WIDTH-1:0] core_state;
  logic [RW-1:0]    core_refr;
  logic             core_fire;
  logic             stall;
  logic             commit;
  logic             last;

  lif_neuron_core #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .RW         (RW)
  ) u_core (
    .state_i      (state_q[idx_q]),
    .refr_i       (refr_q[idx_q]),
    .cur_i        (cur_data),
    .threshold_i  (thr_q),
    .next_state_o (core_state),
    .next_refr_o  (core_refr),
    .fire_o       (core_fire)
  );

  // A firing neuron waits only while an unaccepted spike occupies the register.
  always_comb begin
    stall  = spk_valid_q && !spike_ready && core_fire;
    commit = (fsm_q == S_UPDATE) && !stall;
    last   = (idx_q == IW'(NUM_NEURONS - 1));
  end

  // Next-state logic: accept a step in IDLE, walk the neurons in UPDATE.
  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    case (fsm_q)
      S_IDLE: begin
        if (step_valid) begin
          fsm_d = S_UPDATE;
          idx_d = '0;
        end
      end
      S_UPDATE: begin
        if (commit) begin
          if (last) begin
            fsm_d = S_IDLE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        fsm_d = S_IDLE;
        idx_d = '0;
      end
    endcase
  end

  // Control registers: FSM, index, done pulse, spike register, threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      thr_q       <= WIDTH'(THRESHOLD);
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      done_q <= commit && last;
      if (commit && core_fire) begin
        spk_valid_q <= 1'b1;
        spk_idx_q   <= idx_q;
      end else if (spike_ready) begin
        spk_valid_q <= 1'b0;
      end
      if (fsm_q == S_IDLE && cfg_we) begin
        thr_q <= cfg_threshold;
      end
    end
  end

  // Per-neuron membrane and refractory storage, written on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i] <= '0;
        refr_q[i]  <= '0;
      end
    end else if (commit) begin
      state_q[idx_q] <= core_state;
      refr_q[idx_q]  <= core_refr;
    end
  end

  assign step_ready  = (fsm_q == S_IDLE);
  assign step_done   = done_q;
  assign cur_idx     = idx_q;
  assign spike_valid = spk_valid_q;
  assign spike_idx   = spk_idx_q;
  assign dbg_state   = state_q[dbg_idx];

endmodule
